// File: rtl/risc16_pkg.sv
// Shared encodings for the 16-bit RISC core: opcodes, ALUOp codes, pc_src selects,
// controller state and opcode class.
package risc16_pkg;

   localparam logic [3:0] OP_LW     = 4'h0;
   localparam logic [3:0] OP_SW     = 4'h1;
   localparam logic [3:0] OP_ALU_LO = 4'h2;
   localparam logic [3:0] OP_ALU_HI = 4'h9;
   localparam logic [3:0] OP_BEQ    = 4'hB;
   localparam logic [3:0] OP_BNE    = 4'hC;
   localparam logic [3:0] OP_JMP    = 4'hD;

   localparam logic [1:0] ALUOP_RTYPE = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_ADD   = 2'b10;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_MEM,
      CLS_ALU,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_ILLEGAL
   } op_class_e;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// ctrl_decode: combinational classification of the latched opcode for the multi-cycle controller.
module ctrl_decode
   import risc16_pkg::*;
(
   input  logic [3:0] opcode,
   output op_class_e  op_class,
   output logic       is_load,
   output logic       is_bne
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      if (opcode == OP_LW || opcode == OP_SW) begin
         op_class = CLS_MEM;
      end else if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
         op_class = CLS_ALU;
      end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
         op_class = CLS_BRANCH;
      end else if (opcode == OP_JMP) begin
         op_class = CLS_JUMP;
      end
   end

   assign is_load = (opcode == OP_LW);
   assign is_bne  = (opcode == OP_BNE);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with imem/dmem wait timeout.
// Define ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of treating them as NOPs.
module multi_cycle_ctrl
   import risc16_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   input  logic        dmem_ack,
   input  logic        zero_flag,
   output logic        imem_req,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_op,
   output logic        alu_src,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_we,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic        bus_err,
   output logic        trap,
   output logic [2:0]  state
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e         state_q, state_d;
   logic [3:0]     opcode_q, opcode_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           bus_err_q, bus_err_d;

   op_class_e      op_class;
   logic           is_load;
   logic           is_bne;
   logic           timeout_hit;
   logic           branch_taken;
   logic           unused_instr_bits;

   assign unused_instr_bits = ^instr[11:0];

   ctrl_decode u_decode (
      .opcode   (opcode_q),
      .op_class (op_class),
      .is_load  (is_load),
      .is_bne   (is_bne)
   );

   assign timeout_hit  = (cnt_q == CW'(TIMEOUT - 1));
   assign branch_taken = is_bne ? ~zero_flag : zero_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Counter only advances on waiting cycles; every other path clears it, so each state entry starts at 0.
   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      cnt_d     = '0;
      bus_err_d = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (instr_valid) begin
               opcode_d = instr[15:12];
               state_d  = ST_DECODE;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DECODE: begin
            case (op_class)
               CLS_JUMP: state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
               CLS_ILLEGAL: state_d = ST_TRAP;
`else
               CLS_ILLEGAL: state_d = ST_FETCH;
`endif
               default: state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (op_class)
               CLS_MEM: state_d = ST_MEM;
               CLS_ALU: state_d = ST_WB;
               default: state_d = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (dmem_ack) begin
               state_d = is_load ? ST_WB : ST_FETCH;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               state_d   = ST_FETCH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WB: state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
         ST_TRAP: state_d = ST_TRAP;
`endif
         default: state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_SEQ;
      alu_op     = ALUOP_RTYPE;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_we     = 1'b0;
      dmem_rd    = 1'b0;
      dmem_wr    = 1'b0;
      trap       = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (instr_valid) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            ST_DECODE: begin
               if (op_class == CLS_JUMP) begin
                  pc_we  = 1'b1;
                  pc_src = PC_SRC_JMP;
               end
            end
            ST_EXEC: begin
               case (op_class)
                  CLS_MEM: begin
                     alu_op  = ALUOP_ADD;
                     alu_src = 1'b1;
                  end
                  CLS_BRANCH: begin
                     alu_op = ALUOP_SUB;
                     if (branch_taken) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_BR;
                     end
                  end
                  default: alu_op = ALUOP_RTYPE;
               endcase
            end
            ST_MEM: begin
               dmem_rd = is_load;
               dmem_wr = ~is_load;
            end
            ST_WB: begin
               reg_we     = 1'b1;
               mem_to_reg = is_load;
               reg_dst    = ~is_load;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: trap = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   assign bus_err = bus_err_q & ~rst;
   assign state   = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-instruction expected traces built from the ISA timing rules.
module tb_multi_cycle_ctrl;

  localparam int TO = 16;

  typedef struct packed {
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_src, alu_op;
    logic       alu_src, reg_dst, mem_to_reg, reg_we, dmem_rd, dmem_wr, bus_err, trap;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic        rst, iv, ack, zf;
    logic [15:0] instr;
    out_t        exp;
    string       tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0, dmem_ack = 1'b0, zero_flag = 1'b0;
  logic        imem_req, ir_we, pc_we, alu_src, reg_dst, mem_to_reg, reg_we;
  logic        dmem_rd, dmem_wr, bus_err, trap;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  state;

  int   checks = 0;
  int   errors = 0;
  int   err_exp = 0;
  int   err_seen = 0;
  vec_t vq[$];
  logic pend_err = 1'b0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .dmem_ack(dmem_ack), .zero_flag(zero_flag), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .bus_err(bus_err), .trap(trap), .state(state)
  );

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw();
    return 16'($urandom);
  endfunction

  function automatic void push(logic r, logic iv, logic ack, logic zf, logic [15:0] ins,
                               out_t e, string tag);
    vec_t v;
    v.rst = r; v.iv = iv; v.ack = ack; v.zf = zf; v.instr = ins; v.exp = e; v.tag = tag;
    if (e.bus_err) err_exp++;
    vq.push_back(v);
  endfunction

  function automatic logic take_err();
    logic r = pend_err;
    pend_err = 1'b0;
    return r;
  endfunction

  // One instruction: fw idle fetch cycles, mw cycles of dmem wait (>= TO means no ack ever).
  function automatic void add_instr(logic [15:0] ins, logic zf, int fw, int mw, logic abort_mem);
    out_t       e;
    logic [3:0] op = ins[15:12];
    logic is_mem = (op <= 4'd1);
    logic is_alu = (op >= 4'd2 && op <= 4'd9);
    logic is_br  = (op == 4'd11 || op == 4'd12);
    logic is_jmp = (op == 4'd13);
    logic taken;
    int j = 0;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.imem_req = 1'b1; e.bus_err = take_err();
      push(1'b0, 1'b0, rb(), rb(), rw(), e, "fetch_wait");
      if (j == TO - 1) begin pend_err = 1'b1; j = 0; end
      else j++;
    end
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.bus_err = take_err();
    push(1'b0, 1'b1, rb(), rb(), ins, e, "fetch");
    e = '0; e.state = 3'd1;
    if (is_jmp) begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
    push(1'b0, rb(), rb(), rb(), rw(), e, "decode");
    if (is_jmp) return;
    if (!(is_mem || is_alu || is_br)) begin
`ifdef ILLEGAL_TRAP_EN
      for (int unsigned i = 0; i < 3; i++) begin
        e = '0; e.trap = 1'b1; e.state = 3'd5;
        push(1'b0, rb(), rb(), rb(), rw(), e, "trap_hold");
      end
      push(1'b1, rb(), rb(), rb(), rw(), '0, "trap_rst");
`endif
      return;
    end
    e = '0; e.state = 3'd2;
    if (is_mem) begin e.alu_op = 2'b10; e.alu_src = 1'b1; end
    if (is_br) begin
      e.alu_op = 2'b01;
      taken = (op == 4'd11) ? zf : !zf;
      if (taken) begin e.pc_we = 1'b1; e.pc_src = 2'b01; end
    end
    push(1'b0, rb(), rb(), zf, rw(), e, "exec");
    if (is_br) return;
    if (is_mem) begin
      for (int i = 0; i < TO; i++) begin
        e = '0; e.state = 3'd3; e.dmem_rd = (op == 4'd0); e.dmem_wr = (op == 4'd1);
        push(1'b0, rb(), (i == mw), rb(), rw(), e, "mem");
        if (abort_mem) begin
          push(1'b1, rb(), 1'b0, rb(), rw(), '0, "rst_in_mem");
          return;
        end
        if (i == mw) break;
      end
      if (mw >= TO) begin pend_err = 1'b1; return; end
      if (op == 4'd1) return;
    end
    e = '0; e.state = 3'd4; e.reg_we = 1'b1;
    if (op == 4'd0) e.mem_to_reg = 1'b1; else e.reg_dst = 1'b1;
    push(1'b0, rb(), rb(), rb(), rw(), e, "wb");
  endfunction

  initial begin : main
    out_t got;
    out_t idle;
    idle = '0; idle.imem_req = 1'b1;
    push(1'b1, 1'b1, 1'b0, 1'b0, 16'h2345, '0, "reset0");
    push(1'b1, 1'b1, 1'b0, 1'b0, 16'h2345, '0, "reset1");
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, idle, "post_reset");

    add_instr(16'h2345, 1'b0, 0, 0, 1'b0);
    add_instr(16'h0123, 1'b0, 0, 3, 1'b0);
    add_instr(16'hB000, 1'b1, 0, 0, 1'b0);
    add_instr(16'hB000, 1'b0, 0, 0, 1'b0);
    add_instr(16'hC000, 1'b0, 0, 0, 1'b0);
    add_instr(16'hC000, 1'b1, 0, 0, 1'b0);
    add_instr(16'hD0F0, 1'b0, 0, 0, 1'b0);
    add_instr(16'h1111, 1'b0, 0, TO, 1'b0);
    add_instr(16'h1222, 1'b0, 0, TO - 1, 1'b0);
    add_instr(16'h3000, 1'b0, TO + 2, 0, 1'b0);
    add_instr(16'hF000, 1'b0, 0, 0, 1'b0);
    add_instr(16'hA000, 1'b0, 1, 0, 1'b0);
    add_instr(16'h1333, 1'b0, 0, 0, 1'b1);
    add_instr(16'h0444, 1'b0, 0, 0, 1'b0);
    for (int unsigned n = 0; n < 80; n++) begin
      int mw;
      mw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                       : int'($urandom_range(0, 4));
      add_instr(rw(), rb(), int'($urandom_range(0, 3)), mw, 1'b0);
    end
    add_instr(16'h2000, 1'b0, 0, 0, 1'b0);

    @(posedge clk);
    #1;
    foreach (vq[k]) begin
      rst = vq[k].rst; instr_valid = vq[k].iv; dmem_ack = vq[k].ack;
      zero_flag = vq[k].zf; instr = vq[k].instr;
      @(negedge clk);
      got = '{imem_req, ir_we, pc_we, pc_src, alu_op, alu_src, reg_dst, mem_to_reg,
              reg_we, dmem_rd, dmem_wr, bus_err, trap, state};
      if (bus_err === 1'b1) err_seen++;
      checks++;
      if (got !== vq[k].exp) begin
        errors++;
        $display("FAIL %s vec=%0d got=%b exp=%b", vq[k].tag, k, got, vq[k].exp);
      end
      if (vq[k].rst) begin
        checks++;
        if (got !== out_t'('0)) begin
          errors++;
          $display("FAIL reset_state vec=%0d got=%b", k, got);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (err_seen != err_exp) begin
      errors++;
      $display("FAIL expired_wait bus_err pulses got=%0d exp=%0d", err_seen, err_exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
